input_vc_arbiter: RTL and testbench
===================================

// Module: input_vc_arbiter
// PURPOSE
//  Per-input-port VC arbiter that consumes the per-VC has_packet/dest/output_vc vectors of one input port.
//  Selects one VC: strict priority across classes, round-robin inside a class.
//  Raises a request toward the switch allocator and publishes selected_vc. The VC source uses selected_vc with cts to mark its grant.
//  Holds the grant until the packet's last beat, then re-arbitrates.
// PARAMETERS
//  vc_num      3  VCs per priority class
//  prio_num    2  priority classes; total VCs V = vc_num*prio_num, VC i is in class i/vc_num
//  output_num  8  switch outputs; DW = $clog2(output_num), VW = $clog2(V)
// PORTS
//  clk            in   1        single clock, rising edge
//  reset          in   1        asynchronous, active-high reset
//  i_has_packet   in   V        per-VC packet-pending flags
//  i_dest         in   DW x V   per-VC destination output (unpacked array [V-1:0])
//  i_output_vc    in   VW x V   per-VC requested output VC (unpacked array [V-1:0])
//  i_cts          in   1        clear-to-send from switch allocator for the current request
//  i_last         in   1        last beat of the granted packet
//  o_req          out  1        request valid toward switch allocator
//  o_dest         out  DW       latched destination of the selected VC
//  o_output_vc    out  VW       latched output VC of the selected VC
//  o_selected_vc  out  VW       selected input VC index
//  o_busy         out  1        packet transfer in progress (cts received, last not yet seen)
// BEHAVIOUR
//  Reset: FSM=IDLE, all round-robin pointers=0, o_req=0, o_busy=0, o_dest=0, o_output_vc=0, o_selected_vc=0.
//  FSM states: IDLE, REQ, XFER.
//   IDLE
//    - If |i_has_packet: pick the winner, go to REQ.
//    - Registers latched at the pick: o_selected_vc=winner, o_dest=i_dest[winner], o_output_vc=i_output_vc[winner].
//    - Latency: has_packet seen at edge N -> o_req=1 after edge N+1.
//    - i_cts and i_last are ignored in IDLE.
//   REQ
//    - o_req=1.
//    - i_cts=1 & i_last=0: go to XFER.
//    - i_cts=1 & i_last=1 (single-beat packet): go to IDLE and advance the pointer.
//    - i_has_packet[o_selected_vc]=0 while cts is not yet received: withdraw (packet drop), go to IDLE, pointer unchanged.
//    - Otherwise hold. The selection never changes while in REQ.
//   XFER
//    - o_req=0, o_busy=1.
//    - i_last=1: go to IDLE and advance the pointer.
//    - i_has_packet changes are ignored until last.
//  Winner selection:
//   - Choose the highest class p (prio_num-1 highest) with any pending VC.
//   - Within class p, take the first pending VC at or after rr_ptr[p], with wrap-around inside the class (modulo vc_num).
//  Pointer update: rr_ptr[p] <= (local index of winner + 1) % vc_num, only on packet completion.
//  o_selected_vc, o_dest and o_output_vc are stable from REQ entry until the return to IDLE; they hold their last value in IDLE.
//  One packet at most is in flight. Re-arbitration happens in the cycle after completion, so there is 1 idle cycle between packets.
//  Width rules: all indices are unsigned. The local index is computed modulo vc_num with no overflow for non-power-of-2 vc_num.
//  Reset asserted mid-operation: immediate return to reset values, no pointer retained.
// STRUCTURE
//  Package input_arb_pkg: FSM state enum {IDLE, REQ, XFER} and a class_of(vc) helper function.
//  Sub-module rr_arbiter #(N=vc_num):
//   - Inputs: request vector, pointer.
//   - Outputs: grant one-hot, any, local index.
//   - Instantiated prio_num times, followed by a strict-priority mux.
// TESTING
//  1 Single request: has_packet=6'b000100, dest[2]=5, ovc[2]=2.
//    -> o_req=1 one cycle later, selected_vc=2, o_dest=5, o_output_vc=2.
//    -> cts, then last 4 cycles later -> IDLE, o_busy high for exactly those cycles.
//  2 Priority: has_packet=6'b001001 (VC0 class0, VC3 class1) -> VC3 is selected first, VC0 after VC3 completes.
//  3 Round-robin: has_packet=6'b000111 held, each packet completes
//    -> selected sequence 0,1,2,0 with 1 idle cycle between packets.
//  4 Drop: select VC1, then deassert has_packet[1] before cts
//    -> o_req falls next cycle, the next pick is VC1 again if it re-asserts (pointer unchanged).
//  5 Single-beat: cts and last together in REQ -> straight to IDLE, o_busy never asserts.
//  6 Async reset asserted mid-XFER (between edges) -> o_req=0 and o_busy=0 immediately, pointers=0.

Source files
------------

// File: rtl/input_arb_pkg.sv
// Shared types and helpers for the per-input-port VC arbiter.
package input_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } arb_state_e;

    // Priority class that a flat VC index belongs to.
    function automatic int unsigned class_of(input int unsigned vc, input int unsigned vc_num);
        return vc / vc_num;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter over N requesters: first request at or after the pointer wins, wrapping at N.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic          any_o,
    output logic [PW-1:0] idx_o
);

    logic [N-1:0] masked;
    logic [N-1:0] search;
    logic         found;

    // Requests at or above the pointer are searched first; if none, the whole vector is the wrap-around.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
        masked  = '0;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            masked[i] = req_i[i] && (i >= int'(ptr_i));
        end
        search = (|masked) ? masked : req_i;
        for (int i = 0; i < N; i++) begin
            if (search[i] && !found) begin
                found      = 1'b1;
                grant_o[i] = 1'b1;
                idx_o      = PW'(i);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/input_vc_arbiter.sv
// Per-input-port VC arbiter: strict priority across classes, round-robin within a class,
// request/hold toward the switch allocator until the granted packet's last beat.
module input_vc_arbiter
    import input_arb_pkg::*;
#(
    parameter  int VC_NUM     = 3,
    parameter  int PRIO_NUM   = 2,
    parameter  int OUTPUT_NUM = 8,
    localparam int V          = VC_NUM * PRIO_NUM,
    localparam int DW         = $clog2(OUTPUT_NUM),
    localparam int VW         = $clog2(V)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [V-1:0]  i_has_packet,
    input  logic [DW-1:0] i_dest      [V-1:0],
    input  logic [VW-1:0] i_output_vc [V-1:0],
    input  logic          i_cts,
    input  logic          i_last,
    output logic          o_req,
    output logic [DW-1:0] o_dest,
    output logic [VW-1:0] o_output_vc,
    output logic [VW-1:0] o_selected_vc,
    output logic          o_busy
);

    localparam int PW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    arb_state_e state_q, state_d;

    logic [PW-1:0]     rr_ptr_q [PRIO_NUM];
    logic [PW-1:0]     rr_ptr_d [PRIO_NUM];
    logic [VW-1:0]     sel_vc_q, sel_vc_d;
    logic [DW-1:0]     dest_q, dest_d;
    logic [VW-1:0]     ovc_q, ovc_d;

    logic [VC_NUM-1:0] cls_grant [PRIO_NUM];
    logic [PRIO_NUM-1:0] cls_any;
    logic [PW-1:0]     cls_idx   [PRIO_NUM];

    logic [V-1:0]      win_oh;
    logic [VW-1:0]     win_vc;
    logic [DW-1:0]     win_dest;
    logic [VW-1:0]     win_ovc;

    logic              pick;
    logic              complete;
    int unsigned       sel_class;
    int unsigned       sel_local;
    int unsigned       next_local;

    for (genvar p = 0; p < PRIO_NUM; p++) begin : g_class
        rr_arbiter #(
            .N  (VC_NUM),
            .PW (PW)
        ) u_rr (
            .req_i   (i_has_packet[p*VC_NUM +: VC_NUM]),
            .ptr_i   (rr_ptr_q[p]),
            .grant_o (cls_grant[p]),
            .any_o   (cls_any[p]),
            .idx_o   (cls_idx[p])
        );
    end

    // Higher classes are visited later, so the highest pending class overrides lower ones.
    always_comb begin
        win_oh   = '0;
        win_vc   = '0;
        win_dest = '0;
        win_ovc  = '0;
        for (int p = 0; p < PRIO_NUM; p++) begin
            if (cls_any[p]) begin
                win_oh                       = '0;
                win_oh[p*VC_NUM +: VC_NUM]   = cls_grant[p];
                win_vc                       = VW'(p * VC_NUM) + VW'(cls_idx[p]);
            end
        end
        for (int v = 0; v < V; v++) begin
            if (win_oh[v]) begin
                win_dest = i_dest[v];
                win_ovc  = i_output_vc[v];
            end
        end
    end

    assign pick     = (state_q == IDLE) && (|i_has_packet);
    assign complete = ((state_q == REQ) && i_cts && i_last) ||
                      ((state_q == XFER) && i_last);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (|i_has_packet) state_d = REQ;
            end
            REQ: begin
                if (i_cts)                          state_d = i_last ? IDLE : XFER;
                else if (!i_has_packet[sel_vc_q])   state_d = IDLE;
            end
            XFER: begin
                if (i_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_req  = (state_q == REQ);
        o_busy = (state_q == XFER);
    end

    always_comb begin
        sel_vc_d = sel_vc_q;
        dest_d   = dest_q;
        ovc_d    = ovc_q;
        if (pick) begin
            sel_vc_d = win_vc;
            dest_d   = win_dest;
            ovc_d    = win_ovc;
        end
    end

    // The pointer moves past the finished VC only; a dropped request leaves it in place.
    always_comb begin
        sel_class  = class_of(32'(sel_vc_q), VC_NUM);
        sel_local  = 32'(sel_vc_q) - sel_class * VC_NUM;
        next_local = (sel_local + 1 == VC_NUM) ? 0 : sel_local + 1;
        for (int p = 0; p < PRIO_NUM; p++) begin
            rr_ptr_d[p] = rr_ptr_q[p];
            if (complete && (sel_class == p)) rr_ptr_d[p] = PW'(next_local);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the pointer array is a handful of control flops, not storage, so it is reset with the FSM.
            for (int p = 0; p < PRIO_NUM; p++) rr_ptr_q[p] <= '0;
            sel_vc_q <= '0;
            dest_q   <= '0;
            ovc_q    <= '0;
        end else begin
            for (int p = 0; p < PRIO_NUM; p++) rr_ptr_q[p] <= rr_ptr_d[p];
            sel_vc_q <= sel_vc_d;
            dest_q   <= dest_d;
            ovc_q    <= ovc_d;
        end
    end

    assign o_selected_vc = sel_vc_q;
    assign o_dest        = dest_q;
    assign o_output_vc   = ovc_q;

endmodule

// File: tb/tb_input_vc_arbiter.sv
// Directed bench for input_vc_arbiter with a scoreboard of expected grants.
module tb_input_vc_arbiter;

    localparam int VC_NUM     = 3;
    localparam int PRIO_NUM   = 2;
    localparam int OUTPUT_NUM = 8;
    localparam int V          = VC_NUM * PRIO_NUM;
    localparam int DW         = $clog2(OUTPUT_NUM);
    localparam int VW         = $clog2(V);

    logic          clk = 1'b0;
    logic          reset;
    logic [V-1:0]  has;
    logic [DW-1:0] dest [V-1:0];
    logic [VW-1:0] ovc  [V-1:0];
    logic          cts;
    logic          last;
    logic          o_req;
    logic [DW-1:0] o_dest;
    logic [VW-1:0] o_output_vc;
    logic [VW-1:0] o_selected_vc;
    logic          o_busy;

    typedef struct {
        int vc;
        int dest;
        int ovc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    input_vc_arbiter #(
        .VC_NUM     (VC_NUM),
        .PRIO_NUM   (PRIO_NUM),
        .OUTPUT_NUM (OUTPUT_NUM)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_has_packet  (has),
        .i_dest        (dest),
        .i_output_vc   (ovc),
        .i_cts         (cts),
        .i_last        (last),
        .o_req         (o_req),
        .o_dest        (o_dest),
        .o_output_vc   (o_output_vc),
        .o_selected_vc (o_selected_vc),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Fixed per-VC tables: dest = 7-v, output vc = (5*v) mod 8.
    task automatic push_exp(input int vc);
        exp_t e;
        e.vc   = vc;
        e.dest = 7 - vc;
        e.ovc  = (vc * 5) % 8;
        sb.push_back(e);
    endtask

    task automatic expect_grant(input string tag);
        exp_t e;
        check({tag, "_req"}, o_req, 1);
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_vc"},   o_selected_vc, e.vc);
            check({tag, "_dest"}, o_dest,        e.dest);
            check({tag, "_ovc"},  o_output_vc,   e.ovc);
        end
    endtask

    // cts now, last gap cycles later; o_busy must be high for exactly gap sampled cycles.
    task automatic xfer(input string tag, input int gap, input logic [V-1:0] new_has);
        int busy_cnt;
        cts = 1'b1;
        tick();
        cts = 1'b0;
        check({tag, "_req_off"}, o_req, 0);
        busy_cnt = int'(o_busy);
        repeat (gap - 1) begin
            tick();
            busy_cnt += int'(o_busy);
        end
        last = 1'b1;
        has  = new_has;
        tick();
        last = 1'b0;
        check({tag, "_busy_cycles"}, busy_cnt, gap);
        check({tag, "_busy_end"},    o_busy,   0);
        check({tag, "_idle_gap"},    o_req,    0);
    endtask

    initial begin
        reset = 1'b1;
        has   = '0;
        cts   = 1'b0;
        last  = 1'b0;
        for (int v = 0; v < V; v++) begin
            dest[v] = DW'(7 - v);
            ovc[v]  = VW'((v * 5) % 8);
        end
        #12;
        check("rst_req",  o_req,         0);
        check("rst_busy", o_busy,        0);
        check("rst_vc",   o_selected_vc, 0);
        check("rst_dest", o_dest,        0);
        check("rst_ovc",  o_output_vc,   0);
        reset = 1'b0;
        tick();

        // Single request with a four-cycle transfer.
        has = 6'b000100;
        push_exp(2);
        tick();
        expect_grant("t1");
        xfer("t1", 4, '0);
        tick();
        check("t1_hold_vc", o_selected_vc, 2);
        check("t1_stay_idle", o_req, 0);

        // Class 1 beats class 0.
        has = 6'b001001;
        push_exp(3);
        tick();
        expect_grant("t2a");
        xfer("t2a", 2, 6'b000001);
        push_exp(0);
        tick();
        expect_grant("t2b");
        xfer("t2b", 1, '0);

        // Round-robin from cleared pointers.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        has = 6'b000111;
        for (int i = 0; i < 4; i++) begin
            push_exp(i % 3);
            tick();
            expect_grant($sformatf("t3_%0d", i));
            xfer($sformatf("t3_%0d", i), 2, (i == 3) ? 6'b000000 : 6'b000111);
        end

        // Drop: class 0 pointer is 1, withdraw VC1 before cts, then VC1 wins again.
        has = 6'b000010;
        push_exp(1);
        tick();
        expect_grant("t4a");
        has = '0;
        tick();
        check("t4_drop_req", o_req, 0);
        has = 6'b000011;
        push_exp(1);
        tick();
        expect_grant("t4b");

        // Single-beat packet: cts and last together.
        cts  = 1'b1;
        last = 1'b1;
        has  = '0;
        tick();
        cts  = 1'b0;
        last = 1'b0;
        check("t5_busy", o_busy, 0);
        check("t5_req",  o_req,  0);

        // Class 0 pointer is now 2; async reset mid-transfer must clear it.
        has = 6'b000100;
        push_exp(2);
        tick();
        expect_grant("t6a");
        cts = 1'b1;
        tick();
        cts = 1'b0;
        check("t6_busy", o_busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_req",  o_req,         0);
        check("t6_rst_busy", o_busy,        0);
        check("t6_rst_vc",   o_selected_vc, 0);
        check("t6_rst_dest", o_dest,        0);
        has = '0;
        tick();
        reset = 1'b0;
        has = 6'b000110;
        push_exp(1);
        tick();
        expect_grant("t6b");
        cts  = 1'b1;
        last = 1'b1;
        has  = '0;
        tick();
        cts  = 1'b0;
        last = 1'b0;
        check("t6_end_req", o_req, 0);
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
